// File: rtl/branch_resolve_unit.sv
// Two-stage branch execution unit: S1 captures issued branches, S2 holds the resolved
// completion packet. Predictor training pulses when S2 retires on the CDB.
module branch_resolve_unit #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            squash,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [XLEN-1:0] issue_pc,
    input  logic [XLEN-1:0] issue_rs1,
    input  logic [XLEN-1:0] issue_rs2,
    input  logic [XLEN-1:0] issue_imm,
    input  logic [1:0]      issue_kind,
    input  logic [2:0]      issue_funct3,
    input  logic            issue_pred_taken,
    input  logic [XLEN-1:0] issue_pred_pc,
    input  logic [TAGW-1:0] issue_tag,
    output logic            complete_valid,
    input  logic            complete_ack,
    output logic [TAGW-1:0] complete_tag,
    output logic [XLEN-1:0] complete_result,
    output logic            complete_mispredict,
    output logic [XLEN-1:0] complete_next_pc,
    output logic            update_EN,
    output logic [XLEN-1:0] update_pc,
    output logic            update_direction,
    output logic [XLEN-1:0] update_target
);
    localparam logic [1:0] KIND_COND = 2'b00;
    localparam logic [1:0] KIND_JAL  = 2'b01;
    localparam logic [1:0] KIND_JALR = 2'b10;

    logic            s1_valid;
    logic [XLEN-1:0] s1_pc, s1_rs1, s1_rs2, s1_imm, s1_pred_pc;
    logic [1:0]      s1_kind;
    logic [2:0]      s1_funct3;
    logic            s1_pred_taken;
    logic [TAGW-1:0] s1_tag;

    logic            s2_valid;
    logic [TAGW-1:0] s2_tag;
    logic [XLEN-1:0] s2_result, s2_next_pc, s2_pc, s2_target;
    logic            s2_mispredict, s2_taken;

    logic            retire, advance, accept;
    logic [XLEN-1:0] r_target, r_result, r_next_pc, pc_plus4, jalr_sum;
    logic            r_taken, r_mispredict;

    assign retire      = s2_valid && complete_ack;
    assign advance     = !s2_valid || retire;
    assign issue_ready = !s1_valid || advance;
    assign accept      = issue_valid && issue_ready;

    assign pc_plus4 = s1_pc + XLEN'(4);
    assign jalr_sum = s1_rs1 + s1_imm;

    always_comb begin
        r_target = s1_pc + s1_imm;
        r_taken  = 1'b0;
        r_result = '0;
        case (s1_kind)
            KIND_JAL: begin
                r_taken  = 1'b1;
                r_result = pc_plus4;
            end
            KIND_JALR: begin
                r_target = {jalr_sum[XLEN-1:1], 1'b0};
                r_taken  = 1'b1;
                r_result = pc_plus4;
            end
            KIND_COND: begin
                case (s1_funct3)
                    3'b000:  r_taken = (s1_rs1 == s1_rs2);
                    3'b001:  r_taken = (s1_rs1 != s1_rs2);
                    3'b100:  r_taken = ($signed(s1_rs1) <  $signed(s1_rs2));
                    3'b101:  r_taken = ($signed(s1_rs1) >= $signed(s1_rs2));
                    3'b110:  r_taken = (s1_rs1 <  s1_rs2);
                    3'b111:  r_taken = (s1_rs1 >= s1_rs2);
                    default: r_taken = 1'b0;
                endcase
            end
            default: r_taken = 1'b0;  // illegal kind resolves as a never-taken branch
        endcase
        r_next_pc    = r_taken ? r_target : pc_plus4;
        r_mispredict = (r_taken != s1_pred_taken) ||
                       (r_taken && s1_pred_taken && (r_target != s1_pred_pc));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_pc         <= '0;
            s1_rs1        <= '0;
            s1_rs2        <= '0;
            s1_imm        <= '0;
            s1_kind       <= '0;
            s1_funct3     <= '0;
            s1_pred_taken <= 1'b0;
            s1_pred_pc    <= '0;
            s1_tag        <= '0;
            s2_valid      <= 1'b0;
            s2_tag        <= '0;
            s2_result     <= '0;
            s2_mispredict <= 1'b0;
            s2_next_pc    <= '0;
            s2_pc         <= '0;
            s2_taken      <= 1'b0;
            s2_target     <= '0;
        end else if (squash) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (advance) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_tag        <= s1_tag;
                    s2_result     <= r_result;
                    s2_mispredict <= r_mispredict;
                    s2_next_pc    <= r_next_pc;
                    s2_pc         <= s1_pc;
                    s2_taken      <= r_taken;
                    s2_target     <= r_target;
                end
            end
            if (accept) begin
                s1_valid      <= 1'b1;
                s1_pc         <= issue_pc;
                s1_rs1        <= issue_rs1;
                s1_rs2        <= issue_rs2;
                s1_imm        <= issue_imm;
                s1_kind       <= issue_kind;
                s1_funct3     <= issue_funct3;
                s1_pred_taken <= issue_pred_taken;
                s1_pred_pc    <= issue_pred_pc;
                s1_tag        <= issue_tag;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    assign complete_valid      = s2_valid;
    assign complete_tag        = s2_tag;
    assign complete_result     = s2_result;
    assign complete_mispredict = s2_mispredict;
    assign complete_next_pc    = s2_next_pc;

    assign update_EN        = retire && !squash && !reset;
    assign update_pc        = update_EN ? s2_pc     : '0;
    assign update_direction = update_EN ? s2_taken  : 1'b0;
    assign update_target    = update_EN ? s2_target : '0;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Table-driven bench for branch_resolve_unit with a retire-side scoreboard queue.
module tb_branch_resolve_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        squash = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [31:0] issue_pc = '0, issue_rs1 = '0, issue_rs2 = '0, issue_imm = '0;
    logic [1:0]  issue_kind = '0;
    logic [2:0]  issue_funct3 = '0;
    logic        issue_pred_taken = 1'b0;
    logic [31:0] issue_pred_pc = '0;
    logic [4:0]  issue_tag = '0;
    logic        complete_valid;
    logic        complete_ack = 1'b0;
    logic [4:0]  complete_tag;
    logic [31:0] complete_result;
    logic        complete_mispredict;
    logic [31:0] complete_next_pc;
    logic        update_EN;
    logic [31:0] update_pc;
    logic        update_direction;
    logic [31:0] update_target;

    branch_resolve_unit #(.XLEN(32), .TAGW(5)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_pc(issue_pc), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_imm(issue_imm), .issue_kind(issue_kind), .issue_funct3(issue_funct3),
        .issue_pred_taken(issue_pred_taken), .issue_pred_pc(issue_pred_pc),
        .issue_tag(issue_tag),
        .complete_valid(complete_valid), .complete_ack(complete_ack),
        .complete_tag(complete_tag), .complete_result(complete_result),
        .complete_mispredict(complete_mispredict), .complete_next_pc(complete_next_pc),
        .update_EN(update_EN), .update_pc(update_pc),
        .update_direction(update_direction), .update_target(update_target)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  funct3;
        logic [31:0] pc, rs1, rs2, imm;
        logic        pred_taken;
        logic [31:0] pred_pc;
        logic [4:0]  tag;
        logic        exp_taken;
        logic [31:0] exp_target, exp_next_pc;
        logic        exp_mis;
        logic [31:0] exp_result;
    } vec_t;

    vec_t vec[13];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Retire-side scoreboard plus stall-stability tracking.
    logic        prev_stall = 1'b0;
    logic [4:0]  snap_tag;
    logic [31:0] snap_result, snap_next;
    logic        snap_mis;
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (complete_valid && complete_ack && !squash) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_retire: tag %h with empty scoreboard at %0t",
                             complete_tag, $time);
                end else begin
                    vec_t e;
                    e = exp_q.pop_front();
                    chk("tag", 32'(complete_tag), 32'(e.tag));
                    chk("result", complete_result, e.exp_result);
                    chk("mispredict", 32'(complete_mispredict), 32'(e.exp_mis));
                    chk("next_pc", complete_next_pc, e.exp_next_pc);
                    chk("update_EN_retire", 32'(update_EN), 32'd1);
                    chk("update_pc", update_pc, e.pc);
                    chk("update_direction", 32'(update_direction), 32'(e.exp_taken));
                    chk("update_target", update_target, e.exp_target);
                end
            end else begin
                chk("update_EN_idle", 32'(update_EN), 32'd0);
                chk("update_target_idle", update_target, 32'd0);
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(complete_valid), 32'd1);
                chk("stall_tag", 32'(complete_tag), 32'(snap_tag));
                chk("stall_result", complete_result, snap_result);
                chk("stall_next_pc", complete_next_pc, snap_next);
                chk("stall_mis", 32'(complete_mispredict), 32'(snap_mis));
            end
            prev_stall  = complete_valid && !complete_ack && !squash;
            snap_tag    = complete_tag;
            snap_result = complete_result;
            snap_next   = complete_next_pc;
            snap_mis    = complete_mispredict;
        end
    end

    task automatic drive(input vec_t v);
        issue_kind       = v.kind;
        issue_funct3     = v.funct3;
        issue_pc         = v.pc;
        issue_rs1        = v.rs1;
        issue_rs2        = v.rs2;
        issue_imm        = v.imm;
        issue_pred_taken = v.pred_taken;
        issue_pred_pc    = v.pred_pc;
        issue_tag        = v.tag;
        issue_valid      = 1'b1;
    endtask

    // Offer vector i; record its expectation once the accept edge is certain.
    task automatic send(input int i);
        int n;
        drive(vec[i]);
        n = 0;
        @(negedge clock);
        while (!issue_ready && n < 20) begin
            n++;
            @(negedge clock);
        end
        checks++;
        if (!issue_ready) begin
            errors++;
            $display("FAIL issue_timeout: vector %0d never accepted", i);
        end else begin
            exp_q.push_back(vec[i]);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_valid"}, 32'(complete_valid), 32'd0);
        chk({name, "_tag"}, 32'(complete_tag), 32'd0);
        chk({name, "_result"}, complete_result, 32'd0);
        chk({name, "_mis"}, 32'(complete_mispredict), 32'd0);
        chk({name, "_next_pc"}, complete_next_pc, 32'd0);
        chk({name, "_update_EN"}, 32'(update_EN), 32'd0);
        chk({name, "_update_pc"}, update_pc, 32'd0);
        chk({name, "_update_dir"}, 32'(update_direction), 32'd0);
        chk({name, "_update_target"}, update_target, 32'd0);
        chk({name, "_ready"}, 32'(issue_ready), 32'd1);
    endtask

    initial begin
        // kind funct3 pc rs1 rs2 imm pred pred_pc tag | taken target next_pc mis result
        vec[0]  = '{2'b00, 3'b000, 32'h100, 32'h1, 32'h2, 32'h20, 1'b0, 32'h0, 5'd1,
                    1'b0, 32'h120, 32'h104, 1'b0, 32'h0};
        vec[1]  = '{2'b00, 3'b100, 32'h200, 32'hFFFFFFFF, 32'h1, 32'h10, 1'b0, 32'h0, 5'd2,
                    1'b1, 32'h210, 32'h210, 1'b1, 32'h0};
        vec[2]  = '{2'b00, 3'b110, 32'h300, 32'hFFFFFFFF, 32'h1, 32'h10, 1'b0, 32'h0, 5'd3,
                    1'b0, 32'h310, 32'h304, 1'b0, 32'h0};
        vec[3]  = '{2'b10, 3'b000, 32'h40, 32'h2001, 32'h0, 32'h2, 1'b1, 32'h2000, 5'd4,
                    1'b1, 32'h2002, 32'h2002, 1'b1, 32'h44};
        vec[4]  = '{2'b01, 3'b000, 32'h1000, 32'h0, 32'h0, 32'hFFFFFFF0, 1'b1, 32'hFF0, 5'd5,
                    1'b1, 32'hFF0, 32'hFF0, 1'b0, 32'h1004};
        vec[5]  = '{2'b00, 3'b001, 32'h500, 32'h5, 32'h5, 32'h8, 1'b1, 32'h508, 5'd6,
                    1'b0, 32'h508, 32'h504, 1'b1, 32'h0};
        vec[6]  = '{2'b00, 3'b101, 32'h600, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h40, 1'b1, 32'h640, 5'd7,
                    1'b1, 32'h640, 32'h640, 1'b0, 32'h0};
        vec[7]  = '{2'b00, 3'b111, 32'h700, 32'h1, 32'h80000000, 32'h4, 1'b0, 32'h0, 5'd8,
                    1'b0, 32'h704, 32'h704, 1'b0, 32'h0};
        vec[8]  = '{2'b11, 3'b000, 32'h800, 32'h3, 32'h3, 32'h30, 1'b1, 32'h830, 5'd9,
                    1'b0, 32'h830, 32'h804, 1'b1, 32'h0};
        vec[9]  = '{2'b00, 3'b010, 32'h900, 32'h7, 32'h7, 32'hC, 1'b0, 32'h0, 5'd10,
                    1'b0, 32'h90C, 32'h904, 1'b0, 32'h0};
        vec[10] = '{2'b00, 3'b000, 32'hA00, 32'h7, 32'h7, 32'h100, 1'b1, 32'hA80, 5'd11,
                    1'b1, 32'hB00, 32'hB00, 1'b1, 32'h0};
        vec[11] = '{2'b10, 3'b000, 32'hC00, 32'h3000, 32'h0, 32'hFFFFFFFF, 1'b1, 32'h2FFE, 5'd12,
                    1'b1, 32'h2FFE, 32'h2FFE, 1'b0, 32'hC04};
        vec[12] = '{2'b00, 3'b001, 32'hFFFFFFFC, 32'h1, 32'h1, 32'h8, 1'b0, 32'h0, 5'd13,
                    1'b0, 32'h4, 32'h0, 1'b0, 32'h0};

        // Reset state
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk_all_zero("reset");

        // Latency: accept at edge N, S1 only after N, complete after N+1
        @(posedge clock);
        #1 complete_ack = 1'b1;
        send(0);
        issue_valid = 1'b0;
        @(negedge clock);
        chk("latency_s1_only", 32'(complete_valid), 32'd0);
        @(negedge clock);
        chk("latency_complete", 32'(complete_valid), 32'd1);
        wait_drain();

        // Remaining vectors back to back with ack held
        @(posedge clock);
        #1;
        for (int i = 1; i < 13; i++) send(i);
        issue_valid = 1'b0;
        wait_drain();

        // Back-pressure: three issues, ack low, then release
        @(posedge clock);
        #1 complete_ack = 1'b0;
        send(3);
        send(4);
        drive(vec[5]);
        @(negedge clock);
        chk("bp_ready_full", 32'(issue_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("bp_ready_hold", 32'(issue_ready), 32'd0);
        end
        @(posedge clock);
        #1 complete_ack = 1'b1;
        @(negedge clock);
        chk("bp_ready_release", 32'(issue_ready), 32'd1);
        chk("bp_retire0", 32'(complete_valid), 32'd1);
        exp_q.push_back(vec[5]);
        @(posedge clock);
        #1 issue_valid = 1'b0;
        @(negedge clock);
        chk("bp_retire1", 32'(complete_valid), 32'd1);
        @(negedge clock);
        chk("bp_retire2", 32'(complete_valid), 32'd1);
        @(negedge clock);
        chk("bp_empty", 32'(complete_valid), 32'd0);
        wait_drain();

        // Squash while the first of two branches is being acked
        @(posedge clock);
        #1 drive(vec[6]);
        @(posedge clock);
        #1 drive(vec[7]);
        @(posedge clock);
        #1 begin
            issue_valid = 1'b0;
            squash      = 1'b1;
        end
        @(negedge clock);
        chk("squash_s2_full", 32'(complete_valid), 32'd1);
        chk("squash_no_update", 32'(update_EN), 32'd0);
        @(posedge clock);
        #1 squash = 1'b0;
        @(negedge clock);
        chk("squash_s2_empty", 32'(complete_valid), 32'd0);
        chk("squash_ready", 32'(issue_ready), 32'd1);
        @(negedge clock);
        chk("squash_s1_empty", 32'(complete_valid), 32'd0);

        // Reset with both stages full
        @(posedge clock);
        #1 begin
            complete_ack = 1'b0;
            drive(vec[10]);
        end
        @(posedge clock);
        #1 drive(vec[11]);
        @(posedge clock);
        #1 issue_valid = 1'b0;
        @(negedge clock);
        chk("pre_reset_valid", 32'(complete_valid), 32'd1);
        chk("pre_reset_ready", 32'(issue_ready), 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk_all_zero("midreset");
        @(negedge clock);
        chk("midreset_s1_empty", 32'(complete_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Two-stage branch execution unit for the out-of-order core. It sits between issue and complete, and resolves conditional branches, JAL and JALR. It checks each outcome against the prediction carried with the instruction and reports a mispredict with the corrected next PC. It is also the producer of the predictor training interface (`update_EN` / `update_pc` / `update_direction` / `update_target`): it drives exactly one update pulse per branch that retires from the unit.

## Interface
Parameters:
- `XLEN`, 32, data/address width
- `TAGW`, 5, ROB tag width

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock, all state on posedge
- `reset`  in  1  synchronous, active-high; clears all state
- `squash`  in  1  synchronous flush of both stages
- `issue_valid`  in  1  issue offers an instruction
- `issue_ready`  out  1  unit can accept this cycle
- `issue_pc`  in  XLEN  branch PC
- `issue_rs1`, `issue_rs2`  in  XLEN  operand values
- `issue_imm`  in  XLEN  sign-extended immediate
- `issue_kind`  in  2  00 COND, 01 JAL, 10 JALR, 11 illegal (treated as COND, never taken)
- `issue_funct3`  in  3  RISC-V funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; other values = never taken
- `issue_pred_taken`  in  1  fetch-time predicted direction
- `issue_pred_pc`  in  XLEN  fetch-time predicted target (meaningful only if pred_taken)
- `issue_tag`  in  TAGW  ROB tag
- `complete_valid`  out  1  result valid, held until acked
- `complete_ack`  in  1  CDB grant
- `complete_tag`  out  TAGW  ROB tag
- `complete_result`  out  XLEN  link value pc+4 for JAL/JALR, 0 for COND
- `complete_mispredict`  out  1  prediction wrong
- `complete_next_pc`  out  XLEN  correct next PC
- `update_EN`  out  1  one-cycle predictor training pulse
- `update_pc`  out  XLEN  branch PC
- `update_direction`  out  1  actual taken
- `update_target`  out  XLEN  computed branch target

## Operation
- S1 register: captures the issue fields on accept (`issue_valid && issue_ready`).
- Combinational resolve from S1:
  - `target`: COND/JAL = pc+imm; JALR = (rs1+imm) with bit 0 cleared. All adds are modulo 2^XLEN.
  - `taken`:
    - JAL/JALR: always 1.
    - COND: per funct3. BLT/BGE compare signed; BLTU/BGEU compare unsigned.
  - `next_pc`: taken ? target : pc+4.
  - `mispredict`: (taken != pred_taken) || (taken && pred_taken && target != pred_pc).
- S2 register: holds the resolved packet (tag, result, mispredict, next_pc, pc, taken, target). `complete_valid` = S2 valid.
- Flow:
  - S2 loads from S1 when S2 is empty or is retiring this cycle (`complete_valid && complete_ack`).
  - S1 advances under the same condition.
  - `issue_ready` = !S1.valid || S1 advancing.
- Training:
  - `update_EN` = complete_valid && complete_ack && !squash, combinational in the retire cycle.
  - `update_pc` = S2.pc, `update_direction` = S2.taken, `update_target` = S2.target.
  - When `update_EN` = 0, the update outputs drive 0.
  - The target is sent even when not taken.
- Squash: the next edge clears S1.valid and S2.valid. Any accept or retire in the squash cycle is discarded, and `update_EN` = 0 that cycle.
- Reset: identical to squash and dominates it. It also zeroes all stored payload.

## Timing
- Reset values: `complete_*` = 0, `update_*` = 0, `issue_ready` = 1.
- Latency: accept at edge N → `complete_valid` visible in cycle N+2 (when unstalled).
- Throughput: 1 per cycle while `complete_ack` is held high.
- Stall:
  - S2 waiting without ack: S2 outputs stay stable and unchanged.
  - If S1 is also full, `issue_ready` = 0 and issue must hold its fields.
  - Maximum occupancy is 2.
- Ack with S2 empty: ignored.
- Simultaneous retire and accept: allowed; the pipeline shifts both stages in the same cycle.
- `update_EN` is high for exactly one cycle per retired branch, never during a stall and never twice for one tag.

## Test plan
- Not-taken BEQ, fully predicted: pc=0x100, rs1=1, rs2=2, pred_taken=0, ack held.
  - Cycle N+2: complete_valid=1, mispredict=0, next_pc=0x104.
  - Same cycle: update_EN=1, update_direction=0, update_target=0x100+imm.
- Signed vs unsigned compare: BLT with rs1=0xFFFFFFFF, rs2=1 → taken. BLTU with the same operands → not taken. Each with pred_taken=0:
  - BLT: mispredict=1, next_pc=target.
  - BLTU: mispredict=0.
- JALR target: rs1=0x2001, imm=2, pc=0x40, pred_taken=1, pred_pc=0x2000.
  - target=0x2002, mispredict=1, next_pc=0x2002, result=0x44.
- Back-pressure: 3 back-to-back issues with complete_ack=0 for 4 cycles.
  - issue_ready drops after 2 accepts.
  - S2 outputs stay stable throughout, and update_EN=0 throughout.
  - Release ack → 3 completions on consecutive cycles, in order, each with exactly one update_EN pulse.
- Squash mid-flight: issue 2 branches, assert squash in the cycle the first is being acked.
  - No update_EN that cycle.
  - Both stages empty next cycle; issue_ready=1.
- Reset mid-operation: with S1 and S2 full, assert reset for 1 cycle.
  - All outputs 0 next cycle; issue_ready=1.
